// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers with per-channel phase offset and enable.
// Any accepted valid config write re-syncs every channel and restarts the lock settle window.
module clk_div_bank #(
    parameter int               NCH             = 5,
    parameter int               DW              = 8,
    parameter logic [NCH*DW-1:0] DIV_INIT       = {8'd91, 8'd20, 8'd9, 8'd5, 8'd3},
    parameter logic [NCH*DW-1:0] PHASE_INIT     = '0,
    parameter logic [NCH-1:0]   EN_INIT         = '1,
    parameter int               LOCK_CYCLES     = 16,
    parameter bit               GATE_UNTIL_LOCK = 1'b1,
    localparam int              CHW             = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [DW-1:0]   cfg_div,
    input  logic [DW-1:0]   cfg_phase,
    input  logic            cfg_en,
    output logic            cfg_err,
    output logic [NCH-1:0]  clk_out,
    output logic [NCH-1:0]  tick,
    output logic            extlock
);

    // state  | meaning
    // SYNC   | load every channel counter from its phase, clear settle count
    // SETTLE | counters run, settle count advances, extlock low
    // LOCKED | extlock high and held until the next valid write
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    state_t          r_state, w_state_nxt;
    logic [LCW-1:0]  r_settle, w_settle_nxt;

    logic [DW-1:0]   r_div   [NCH];
    logic [DW-1:0]   r_phase [NCH];
    logic [NCH-1:0]  r_en;
    logic [DW-1:0]   r_cnt   [NCH];
    logic [DW-1:0]   w_cnt_nxt [NCH];

    logic [NCH-1:0]  r_clk_out, r_tick, w_clk_nxt, w_tick_nxt;
    logic            r_extlock, r_ready, r_err;
    logic            w_accept, w_cfg_ok, w_good, w_bad, w_gate;

    always_comb begin
        w_accept = cfg_valid & r_ready;
        w_cfg_ok = (int'(cfg_ch) < NCH) && (cfg_div >= DW'(2)) && (cfg_phase < cfg_div);
        w_good   = w_accept & w_cfg_ok;
        w_bad    = w_accept & ~w_cfg_ok;

        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        case (r_state)
            ST_SYNC: begin
                w_state_nxt  = ST_SETTLE;
                w_settle_nxt = '0;
            end
            ST_SETTLE: begin
                w_settle_nxt = r_settle + LCW'(1);
                if (w_good)
                    w_state_nxt = ST_SYNC;
                else if (r_settle == LCW'(LOCK_CYCLES - 1))
                    w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_good)
                    w_state_nxt = ST_SYNC;
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    // Outputs are registered from the next counter value so they line up with the counter itself.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_clk_nxt  = '0;
        w_tick_nxt = '0;
        w_gate     = GATE_UNTIL_LOCK ? (w_state_nxt == ST_LOCKED) : 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (!r_en[i])
                w_cnt_nxt[i] = '0;
            else if (r_state == ST_SYNC)
                w_cnt_nxt[i] = (r_phase[i] == '0) ? '0 : (r_div[i] - r_phase[i]);
            else if (r_cnt[i] >= r_div[i] - DW'(1))
                w_cnt_nxt[i] = '0;
            else
                w_cnt_nxt[i] = r_cnt[i] + DW'(1);
            w_clk_nxt[i]  = r_en[i] & w_gate & (w_cnt_nxt[i] < (r_div[i] >> 1));
            w_tick_nxt[i] = r_en[i] & w_gate & (w_cnt_nxt[i] == '0);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= ST_SYNC;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_extlock <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_clk_out <= '0;
            r_tick    <= '0;
            r_en      <= EN_INIT;
            for (int i = 0; i < NCH; i++) begin
                r_div[i]   <= DIV_INIT[i*DW +: DW];
                r_phase[i] <= PHASE_INIT[i*DW +: DW];
                r_cnt[i]   <= '0;
            end
        end else begin
            r_extlock <= (w_state_nxt == ST_LOCKED);
            r_ready   <= (w_state_nxt != ST_SYNC);
            r_err     <= w_bad;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                if (w_good && (cfg_ch == CHW'(i))) begin
                    r_div[i]   <= cfg_div;
                    r_phase[i] <= cfg_phase;
                    r_en[i]    <= cfg_en;
                end
            end
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign extlock   = r_extlock;

endmodule
